// File: rtl/control_unit.sv
// Hardwired control sequencer for the mini-SRC CPU: fetch, decode IR[31:27],
// and walk each instruction's control steps, one step per clock.
module control_unit #(
  parameter logic [4:0] ALU_ADD_ADDR = 5'b00001,
  parameter logic [4:0] ALU_ADD_PC   = 5'b00011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        ba_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_HALT  = 4'd9
  } step_e;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_BR   = 5'b10010,
    OP_JR   = 5'b10011,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_e;

  step_e      step_q, step_d;
  logic [4:0] opcode;
  logic       unused_ir;

  logic is_ld, is_ldi, is_st, is_imm, is_br, is_jr, is_halt;
  logic is_mem;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];

  always_comb begin
    is_ld   = (opcode == OP_LD);
    is_ldi  = (opcode == OP_LDI);
    is_st   = (opcode == OP_ST);
    is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    is_br   = (opcode == OP_BR);
    is_jr   = (opcode == OP_JR);
    is_halt = (opcode == OP_HALT);
    is_mem  = is_ld || is_ldi || is_st;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) step_q <= S_RESET;
    else          step_q <= step_d;
  end

  // Every path returns to T0; anything unexpected (including illegal step
  // codes) falls back to RESET so the sequencer always recovers.
  always_comb begin
    step_d = S_RESET;
    case (step_q)
      S_RESET: step_d = S_T0;
      S_T0:    step_d = S_T1;
      S_T1:    step_d = S_T2;
      S_T2:    step_d = S_T3;
      S_T3: begin
        if (is_halt)                      step_d = S_HALT;
        else if (is_mem || is_imm || is_br) step_d = S_T4;
        else                              step_d = S_T0;
      end
      S_T4: begin
        if (is_mem || is_imm || is_br) step_d = S_T5;
        else                           step_d = S_T0;
      end
      S_T5: begin
        if (is_ld || is_st || is_br) step_d = S_T6;
        else                         step_d = S_T0;
      end
      S_T6: begin
        if (is_ld || is_st) step_d = S_T7;
        else                step_d = S_T0;
      end
      S_T7:    step_d = S_T0;
      S_HALT:  step_d = S_HALT;
      default: step_d = S_RESET;
    endcase
  end

  always_comb begin
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    con_enable          = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    ba_select           = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    alu_instruction     = '0;
    run                 = 1'b1;
    step                = step_q;

    case (step_q)
      S_T0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end
      S_T1: begin
        PC_increment_enable = 1'b1;
        read                = 1'b1;
        MDR_enable          = 1'b1;
      end
      S_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        if (is_mem) begin
          Grb       = 1'b1;
          ba_select = 1'b1;
          Y_enable  = 1'b1;
        end else if (is_imm) begin
          Grb      = 1'b1;
          r_select = 1'b1;
          Y_enable = 1'b1;
        end else if (is_br) begin
          Gra        = 1'b1;
          r_select   = 1'b1;
          con_enable = 1'b1;
        end else if (is_jr) begin
          Gra       = 1'b1;
          r_select  = 1'b1;
          PC_enable = 1'b1;
        end
      end
      S_T4: begin
        if (is_mem) begin
          c_select        = 1'b1;
          alu_instruction = ALU_ADD_ADDR;
          Z_enable        = 1'b1;
        end else if (is_imm) begin
          c_select        = 1'b1;
          alu_instruction = opcode;
          Z_enable        = 1'b1;
        end else if (is_br) begin
          PC_select = 1'b1;
          Y_enable  = 1'b1;
        end
      end
      S_T5: begin
        if (is_ldi || is_imm) begin
          Z_LO_select = 1'b1;
          Gra         = 1'b1;
          r_enable    = 1'b1;
        end else if (is_ld || is_st) begin
          Z_LO_select = 1'b1;
          MAR_enable  = 1'b1;
        end else if (is_br) begin
          c_select        = 1'b1;
          alu_instruction = ALU_ADD_PC;
          Z_enable        = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          read       = 1'b1;
          MDR_enable = 1'b1;
        end else if (is_st) begin
          Gra        = 1'b1;
          r_select   = 1'b1;
          MDR_enable = 1'b1;
        end else if (is_br) begin
          Z_LO_select = 1'b1;
          PC_enable   = con_output;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
        end else if (is_st) begin
          write = 1'b1;
        end
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions compared cycle by
// cycle against per-instruction control-word lists built from the ISA rules.
module tb_control_unit;

  localparam logic [4:0] ALU_ADDR = 5'b00001;
  localparam logic [4:0] ALU_PC   = 5'b00011;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011, OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic       pc_en, pc_inc, ir_en, y_en, z_en, mar_en, mdr_en, r_en, con_en;
    logic       rd, wr, gra, grb, ba, pc_sel, zlo_sel, mdr_sel, c_sel, r_sel;
    logic [4:0] alu;
    logic       run;
    logic [3:0] step;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir_data;
  logic        con_output;
  logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic        MAR_enable, MDR_enable, r_enable, con_enable, read, write;
  logic        Gra, Grb, ba_select, PC_select, Z_LO_select, MDR_select;
  logic        c_select, r_select, run;
  logic [4:0]  alu_instruction;
  logic [3:0]  step;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  ctl_t        obs;
  ctl_t        exp_q[$];

  control_unit #(.ALU_ADD_ADDR(ALU_ADDR), .ALU_ADD_PC(ALU_PC)) dut (
    .clk(clk), .reset_n(reset_n), .IR_Data(ir_data), .con_output(con_output),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .con_enable(con_enable), .read(read), .write(write), .Gra(Gra), .Grb(Grb),
    .ba_select(ba_select), .PC_select(PC_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .c_select(c_select), .r_select(r_select),
    .alu_instruction(alu_instruction), .run(run), .step(step)
  );

  always #5 clk = ~clk;

  assign obs = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                MAR_enable, MDR_enable, r_enable, con_enable, read, write, Gra,
                Grb, ba_select, PC_select, Z_LO_select, MDR_select, c_select,
                r_select, alu_instruction, run, step};

  function automatic ctl_t mk(input int unsigned s);
    ctl_t c = '0;
    c.run  = (s != 9);
    c.step = s[3:0];
    return c;
  endfunction

  // Control-word list for one instruction, fetch included; halt ends at T3.
  function automatic void build(input logic [31:0] ir, input logic con);
    logic [4:0] op = ir[31:27];
    ctl_t c;
    exp_q.delete();
    c = mk(0); c.pc_sel = 1; c.mar_en = 1;            exp_q.push_back(c);
    c = mk(1); c.pc_inc = 1; c.rd = 1; c.mdr_en = 1;  exp_q.push_back(c);
    c = mk(2); c.mdr_sel = 1; c.ir_en = 1;            exp_q.push_back(c);
    c = mk(3);
    if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
      c.grb = 1; c.ba = 1; c.y_en = 1;                 exp_q.push_back(c);
      c = mk(4); c.c_sel = 1; c.alu = ALU_ADDR; c.z_en = 1; exp_q.push_back(c);
      c = mk(5); c.zlo_sel = 1;
      if (op == OP_LDI) begin c.gra = 1; c.r_en = 1; end
      else c.mar_en = 1;
      exp_q.push_back(c);
      if (op == OP_LD) begin
        c = mk(6); c.rd = 1; c.mdr_en = 1;                 exp_q.push_back(c);
        c = mk(7); c.mdr_sel = 1; c.gra = 1; c.r_en = 1;   exp_q.push_back(c);
      end else if (op == OP_ST) begin
        c = mk(6); c.gra = 1; c.r_sel = 1; c.mdr_en = 1;   exp_q.push_back(c);
        c = mk(7); c.wr = 1;                               exp_q.push_back(c);
      end
    end else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) begin
      c.grb = 1; c.r_sel = 1; c.y_en = 1;              exp_q.push_back(c);
      c = mk(4); c.c_sel = 1; c.alu = op; c.z_en = 1;  exp_q.push_back(c);
      c = mk(5); c.zlo_sel = 1; c.gra = 1; c.r_en = 1; exp_q.push_back(c);
    end else if (op == OP_BR) begin
      c.gra = 1; c.r_sel = 1; c.con_en = 1;            exp_q.push_back(c);
      c = mk(4); c.pc_sel = 1; c.y_en = 1;             exp_q.push_back(c);
      c = mk(5); c.c_sel = 1; c.alu = ALU_PC; c.z_en = 1; exp_q.push_back(c);
      c = mk(6); c.zlo_sel = 1; c.pc_en = con;         exp_q.push_back(c);
    end else if (op == OP_JR) begin
      c.gra = 1; c.r_sel = 1; c.pc_en = 1;             exp_q.push_back(c);
    end else begin
      exp_q.push_back(c);
    end
  endfunction

  task automatic check(input ctl_t e, input string tag);
    @(negedge clk);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  // abort_at >= 0 pulls reset_n low during that step of the instruction.
  task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_at);
    logic [31:0] junk;
    build(ir, con);
    con_output = con;
    foreach (exp_q[i]) begin
      junk = $urandom();
      ir_data = (i >= 3) ? ir : junk;
      if (i == abort_at) reset_n = 1'b0;
      check(exp_q[i], $sformatf("op%b_T%0d", ir[31:27], i));
      if (i == abort_at) break;
    end
    if (abort_at >= 0) begin
      reset_n = 1'b1;
      check(mk(8), "abort_reset");
    end else if (ir[31:27] == OP_HALT) begin
      repeat (20) check(mk(9), "halt_hold");
      reset_n = 1'b0;
      check(mk(9), "halt_pre_reset");
      reset_n = 1'b1;
      check(mk(8), "halt_reset");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  ops [9];
    logic [4:0]  op;
    logic [31:0] r;
    ops = '{OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_NOP};

    reset_n = 1'b0; ir_data = '0; con_output = 1'b0;
    @(posedge clk); #1;
    check(mk(8), "reset_0");
    check(mk(8), "reset_1");
    reset_n = 1'b1;
    check(mk(8), "reset_release");

    run_instr(32'h0900_0065, 1'b0, -1);
    run_instr(32'h0000_0055, 1'b1, -1);
    run_instr(32'h1080_0087, 1'b0, -1);
    run_instr(32'h9100_0023, 1'b1, -1);
    run_instr(32'h9100_0023, 1'b0, -1);
    run_instr(32'h7000_0025, 1'b1, -1);
    run_instr(32'h9800_0000, 1'b0, -1);
    run_instr(32'h6000_0011, 1'b0, -1);
    run_instr(32'h6800_0011, 1'b1, -1);
    run_instr(32'hD000_0000, 1'b1, -1);
    run_instr(32'hF800_0000, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        op = r[31:27];
        if (op == OP_HALT) op = OP_NOP;
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)), -1);
    end

    run_instr(32'hD800_0000, 1'b0, -1);
    run_instr(32'h0000_0055, 1'b0, 5);
    run_instr(32'h0900_0065, 1'b1, -1);
    build(32'h0, 1'b0);
    check(exp_q[0], "final_T0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the mini-SRC CPU. It sits directly upstream of `datapath` and drives every datapath enable, select and ALU-opcode input, one control step per clock. It fetches instructions, decodes the opcode field of `IR_Data`, and walks the per-instruction step sequence. It samples `con_output` to resolve conditional branches.

## Interface
Parameters:
- `ALU_ADD_ADDR`, default 5'b00001: ALU code for effective-address and immediate adds (ld, ldi, st).
- `ALU_ADD_PC`, default 5'b00011: ALU code for the PC-relative branch target add.

Ports (clock and reset: one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `IR_Data`  in  32  instruction register; opcode = [31:27]
- `con_output`  in  1  CON FF result from datapath
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`, `con_enable`  out  1 each  register load enables
- `read`, `write`  out  1 each  memory read/MDR-mux select, memory write
- `Gra`, `Grb`, `ba_select`  out  1 each  select-and-encode controls
- `PC_select`, `Z_LO_select`, `MDR_select`, `c_select`, `r_select`  out  1 each  bus-encoder selects
- `alu_instruction`  out  5  ALU opcode
- `run`  out  1  high while sequencing, low in HALT
- `step`  out  4  current step (debug): 0–7 = T0–T7, 8 = RESET, 9 = HALT

## Operation
Opcodes (IR[31:27]):
- ld 00000, ldi 00001, st 00010
- addi 01100, andi 01101, ori 01110
- br 10010, jr 10011, nop 11010, halt 11011
- Any other value executes as nop.

State is a step register. Outputs are a combinational decode of (step, IR[31:27]). Only `con_output` feeds an output directly. Every signal not listed in a step is 0.

Fetch, common to all instructions:
- T0: `PC_select`, `MAR_enable`.
- T1: `PC_increment_enable`, `read`, `MDR_enable`.
- T2: `MDR_select`, `IR_enable`.
- IR is valid from T3 onward and is held constant until the next T2.

Execute steps:
- ldi: T3 `Grb`, `ba_select`, `Y_enable`; T4 `c_select`, alu=ALU_ADD_ADDR, `Z_enable`; T5 `Z_LO_select`, `Gra`, `r_enable`; then T0.
- ld: T3/T4 as ldi; T5 `Z_LO_select`, `MAR_enable`; T6 `read`, `MDR_enable`; T7 `MDR_select`, `Gra`, `r_enable`; then T0.
- st: T3–T5 as ld; T6 `Gra`, `r_select`, `MDR_enable` (read=0); T7 `write`; then T0.
- addi/andi/ori: T3 `Grb`, `r_select`, `Y_enable`; T4 `c_select`, alu=IR[31:27], `Z_enable`; T5 `Z_LO_select`, `Gra`, `r_enable`; then T0.
- br: T3 `Gra`, `r_select`, `con_enable`; T4 `PC_select`, `Y_enable`; T5 `c_select`, alu=ALU_ADD_PC, `Z_enable`; T6 `Z_LO_select`, `PC_enable`=`con_output`; then T0.
- jr: T3 `Gra`, `r_select`, `PC_enable`; then T0.
- nop/unknown: T3 with no signals asserted; then T0.
- halt: T3 with no signals asserted; then HALT. HALT is absorbing, all outputs 0, `run`=0, and only reset exits it.

## Timing
- Each step lasts exactly one `clk` cycle. Signals are asserted for the whole cycle, and the datapath captures at the rising edge that ends the step.
- Instruction latency in cycles: ldi 6, addi/andi/ori 6, ld 8, st 8, br 7, jr 4, nop 4, halt 4 to reach HALT.
- Reset:
  - `reset_n`=0 at any rising edge forces step=RESET, regardless of the current step (including mid-instruction and HALT).
  - In RESET all control outputs are 0, `alu_instruction`=0, `run`=1, `step`=8.
  - The first edge with `reset_n`=1 moves to T0.
  - A half-finished instruction is abandoned with no further enables asserted.
- The br T6 `PC_enable` follows `con_output` combinationally. `con_output` is stable from the end of T3, so there is no glitch within T6.
- `step` wraps from T5/T6/T7 (or T3) back to T0 only. No step value beyond 9 is reachable; an illegal value recovers to RESET on the next edge.
- `write` and `read` are never high in the same cycle.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles, then release → all outputs 0, `step`=8 during reset; `step`=0 with `PC_select`=`MAR_enable`=1 on the first cycle after release.
- ldi: IR=0x0900_0065 (ldi R2,0x65) supplied at T3 → exact T0–T5 pattern, `alu_instruction`=00001 in T4 only, `r_enable`+`Gra` in T5, `step`=0 on cycle 7.
- ld, then st: IR=0x0000_0055 → 8-cycle sequence, `read` in T1 and T6; IR=0x1080_0087 → `write` high only in T7, `read` never in T6.
- br taken vs. not taken: IR=0x9100_0023 with `con_output`=1, then 0 → `PC_enable`=1, then 0, in T6; `alu_instruction`=00011 in T5.
- ori and jr: IR=0x7000_0025 → `alu_instruction`=01110 in T4; IR=0x9800_0000 → `PC_enable`+`r_select`+`Gra` in T3 and T0 on the next cycle.
- halt, then reset mid-instruction: IR=0xD800_0000 → HALT with `run`=0 held for 20 cycles; assert `reset_n`=0 during ld T5 → no `MAR_enable` at T5's successor, `step`=8.
